// File: rtl/bcd_seg_counter.sv
// Parameterised up/down BCD counter with synchronous load, modulus wrap and
// a combinational seven-segment decode (optional leading-zero blanking).
module bcd_seg_counter #(
   parameter int DIGITS         = 2,
   parameter int MODULUS        = 100,
   parameter int BLANK_LZ       = 1,
   parameter int SEG_ACTIVE_LOW = 1
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                en,
   input  logic                up,
   input  logic                load,
   input  logic [4*DIGITS-1:0] load_val,
   output logic [4*DIGITS-1:0] count_bcd,
   output logic [7*DIGITS-1:0] result,
   output logic                wrap,
   output logic                load_err
);

   localparam int W = 4 * DIGITS;

   function automatic logic [W-1:0] to_bcd(input int v);
      int t;
      logic [W-1:0] r;
      t = v;
      r = '0;
      for (int i = 0; i < DIGITS; i++) begin
         r[i*4 +: 4] = 4'(t % 10);
         t = t / 10;
      end
      return r;
   endfunction

   localparam logic [W-1:0] MAX_BCD = to_bcd(MODULUS - 1);

   // Patterns are held active-low and inverted at the output when needed.
   function automatic logic [6:0] seg_pattern(input logic [3:0] d);
      logic [6:0] p;
      case (d)
         4'd0:    p = 7'b0000001;
         4'd1:    p = 7'b1001111;
         4'd2:    p = 7'b0010010;
         4'd3:    p = 7'b0000110;
         4'd4:    p = 7'b1001100;
         4'd5:    p = 7'b0100100;
         4'd6:    p = 7'b0100000;
         4'd7:    p = 7'b0001111;
         4'd8:    p = 7'b0000000;
         4'd9:    p = 7'b0000100;
         default: p = 7'b1111111;
      endcase
      return p;
   endfunction

   logic [W-1:0] count_q;
   logic [W-1:0] count_inc;
   logic [W-1:0] count_dec;
   logic         load_ok;
   logic         digits_ok;
   logic         carry;
   logic         borrow;
   logic         wrap_q;
   logic         load_err_q;

   // With every digit in 0..9, a plain binary compare orders BCD values correctly.
   always_comb begin
      digits_ok = 1'b1;
      for (int i = 0; i < DIGITS; i++) begin
         if (load_val[i*4 +: 4] > 4'd9) digits_ok = 1'b0;
      end
      load_ok = digits_ok && (load_val <= MAX_BCD);
   end

   always_comb begin
      count_inc = count_q;
      count_dec = count_q;
      carry     = 1'b1;
      borrow    = 1'b1;
      for (int i = 0; i < DIGITS; i++) begin
         if (carry) begin
            if (count_q[i*4 +: 4] == 4'd9) begin
               count_inc[i*4 +: 4] = 4'd0;
            end else begin
               count_inc[i*4 +: 4] = count_q[i*4 +: 4] + 4'd1;
               carry = 1'b0;
            end
         end
         if (borrow) begin
            if (count_q[i*4 +: 4] == 4'd0) begin
               count_dec[i*4 +: 4] = 4'd9;
            end else begin
               count_dec[i*4 +: 4] = count_q[i*4 +: 4] - 4'd1;
               borrow = 1'b0;
            end
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_q    <= '0;
         wrap_q     <= 1'b0;
         load_err_q <= 1'b0;
      end else begin
         wrap_q     <= 1'b0;
         load_err_q <= 1'b0;
         if (load) begin
            if (load_ok) count_q <= load_val;
            else         load_err_q <= 1'b1;
         end else if (en) begin
            if (up) begin
               if (count_q == MAX_BCD) begin
                  count_q <= '0;
                  wrap_q  <= 1'b1;
               end else begin
                  count_q <= count_inc;
               end
            end else begin
               if (count_q == '0) begin
                  count_q <= MAX_BCD;
                  wrap_q  <= 1'b1;
               end else begin
                  count_q <= count_dec;
               end
            end
         end
      end
   end

   logic       upper_zero;
   logic [3:0] dig;
   logic [6:0] pat;

   // Walk from the top digit down; a digit blanks while everything above it is zero.
   always_comb begin
      result     = '0;
      upper_zero = 1'b1;
      dig        = 4'd0;
      pat        = 7'b1111111;
      for (int i = DIGITS - 1; i >= 0; i--) begin
         dig        = count_q[i*4 +: 4];
         upper_zero = upper_zero && (dig == 4'd0);
         if ((BLANK_LZ != 0) && (i != 0) && upper_zero) pat = 7'b1111111;
         else                                           pat = seg_pattern(dig);
         result[i*7 +: 7] = (SEG_ACTIVE_LOW != 0) ? pat : ~pat;
      end
   end

   assign count_bcd = count_q;
   assign wrap      = wrap_q;
   assign load_err  = load_err_q;

endmodule
